logit8_piped: RTL and testbench

Pipelined piecewise-linear inverse sigmoid (logit) for 16-bit sign-magnitude Q4.11 data. It maps a probability y in [0, 1] back to x ≈ ln(y/(1−y)). It reuses the 9-segment line set of the forward sigmoid unit, inverted segment by segment, so sigmoid-then-logit round-trips to within a few LSB. It sits on the decode/feedback side of the activation datapath and accepts one sample per clock with a valid tag.

---
 rtl/logit8_pkg.sv | 36 +++
 rtl/logit8_piped_segment_sel.sv | 33 +++
 rtl/logit8_piped.sv | 100 ++++++++++
 tb/tb_logit8_piped.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/logit8_pkg.sv
// Shared widths and the inverted 9-segment line set used by the logit pipeline.
// Segment constants mirror the forward sigmoid so the two units round-trip.
package logit8_pkg;

    localparam int FRAC   = 11;
    localparam int MAG    = 15;
    localparam int K_W    = 20;
    localparam int PROD_W = 31;
    localparam int Y_W    = 12;
    localparam int DIFF_W = 11;

    localparam logic [Y_W-1:0] ONE  = 12'd2048;
    localparam logic [Y_W-1:0] HALF = 12'd1024;

    // Inclusive upper bounds of y' for segments R5..R8; R9 takes the rest
    localparam logic [Y_W-1:0] Y5 = 12'd1514;
    localparam logic [Y_W-1:0] Y6 = 12'd1782;
    localparam logic [Y_W-1:0] Y7 = 12'd1941;
    localparam logic [Y_W-1:0] Y8 = 12'd2020;

    localparam logic [Y_W-1:0] C5 = 12'd1024;
    localparam logic [Y_W-1:0] C6 = 12'd1190;
    localparam logic [Y_W-1:0] C7 = 12'd1484;
    localparam logic [Y_W-1:0] C8 = 12'd1789;
    localparam logic [Y_W-1:0] C9 = 12'd1995;

    // Inverse slopes 1/m in unsigned Q9.11
    localparam logic [K_W-1:0] K5 = 20'd8924;
    localparam logic [K_W-1:0] K6 = 20'd13530;
    localparam logic [K_W-1:0] K7 = 20'd26887;
    localparam logic [K_W-1:0] K8 = 20'd80660;
    localparam logic [K_W-1:0] K9 = 20'd699051;

    localparam logic [MAG-1:0] MAG_MAX = 15'h7FFF;

endpackage

// File: rtl/logit8_piped_segment_sel.sv
// Combinational segment lookup: picks the line for y' and returns its offset and inverse slope.
module logit_segment_sel
    import logit8_pkg::*;
(
    input  logic [Y_W-1:0]    y_prime,
    output logic [DIFF_W-1:0] diff,
    output logic [K_W-1:0]    k
);

    logic [Y_W-1:0] c;

    always_comb begin
        c = C9;
        k = K9;
        if (y_prime <= Y5) begin
            c = C5;
            k = K5;
        end else if (y_prime <= Y6) begin
            c = C6;
            k = K6;
        end else if (y_prime <= Y7) begin
            c = C7;
            k = K7;
        end else if (y_prime <= Y8) begin
            c = C8;
            k = K8;
        end
    end

    // y' never falls below the chosen intercept, so the low 11 bits hold the full offset
    assign diff = DIFF_W'(y_prime - c);

endmodule

// File: rtl/logit8_piped.sv
// Four-stage piecewise-linear logit for sign-magnitude Q4.11 probabilities.
// Stages: clamp/mirror, segment select, multiply, shift/saturate/sign.
module logit8_piped
    import logit8_pkg::*;
#(
    parameter int BITSIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BITSIZE-1:0] data_in,
    input  logic               in_valid,
    output logic [BITSIZE-1:0] data_out,
    output logic               out_valid
);

    logic [Y_W-1:0]    y_clamp;
    logic [Y_W-1:0]    y_mirror;
    logic              neg_in;

    logic              valid1;
    logic [Y_W-1:0]    y_prime1;
    logic              neg1;

    logic [DIFF_W-1:0] diff_sel;
    logic [K_W-1:0]    k_sel;
    logic              valid2;
    logic [DIFF_W-1:0] diff2;
    logic [K_W-1:0]    k2;
    logic              neg2;

    logic              valid3;
    logic [PROD_W-1:0] prod3;
    logic              neg3;

    logic [PROD_W-1:0] shifted;
    logic [MAG-1:0]    mag_sat;

    // Negative probabilities clamp to 0, anything above 1.0 clamps to 1.0
    always_comb begin
        y_clamp = '0;
        if (!data_in[BITSIZE-1]) begin
            if (data_in[MAG-1:0] > MAG'(ONE))
                y_clamp = ONE;
            else
                y_clamp = data_in[Y_W-1:0];
        end
        neg_in   = (y_clamp < HALF);
        y_mirror = neg_in ? (ONE - y_clamp) : y_clamp;
    end

    logit_segment_sel u_segment_sel (
        .y_prime (y_prime1),
        .diff    (diff_sel),
        .k       (k_sel)
    );

    always_comb begin
        shifted = prod3 >> FRAC;
        mag_sat = (shifted > PROD_W'(MAG_MAX)) ? MAG_MAX : shifted[MAG-1:0];
    end

    // Valid bits always advance; data registers only load when their stage receives a sample
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1    <= 1'b0;
            y_prime1  <= '0;
            neg1      <= 1'b0;
            valid2    <= 1'b0;
            diff2     <= '0;
            k2        <= '0;
            neg2      <= 1'b0;
            valid3    <= 1'b0;
            prod3     <= '0;
            neg3      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            valid1    <= in_valid;
            valid2    <= valid1;
            valid3    <= valid2;
            out_valid <= valid3;
            if (in_valid) begin
                y_prime1 <= y_mirror;
                neg1     <= neg_in;
            end
            if (valid1) begin
                diff2 <= diff_sel;
                k2    <= k_sel;
                neg2  <= neg1;
            end
            if (valid2) begin
                prod3 <= PROD_W'(diff2) * PROD_W'(k2);
                neg3  <= neg2;
            end
            if (valid3)
                data_out <= {neg3 & (mag_sat != '0), mag_sat};
        end
    end

endmodule

// File: tb/tb_logit8_piped.sv
// Directed bench for logit8_piped: hand-computed vectors, reset behaviour and an R5 round-trip sweep.
module tb_logit8_piped;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        in_valid;
    logic [15:0] data_out;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    // Expected-latency model: one slot per pipeline register
    logic        mv [4];
    logic [15:0] mexp [4];
    logic        mtol [4];
    logic [15:0] exp_data;
    logic        data_known;

    logit8_piped #(.BITSIZE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int sm2int(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    // Drives one cycle; tol marks a round-trip sample whose expectation is the original x code
    task automatic applyStimulus(input logic rst, input logic vld, input logic [15:0] din,
                                 input logic [15:0] expv, input logic tol);
        int err;
        reset    = rst;
        in_valid = vld;
        data_in  = din;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 1'b0;
                mexp[i] = '0;
                mtol[i] = 1'b0;
            end
            exp_data   = '0;
            data_known = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) begin
                mv[i] = mv[i-1];
                mexp[i] = mexp[i-1];
                mtol[i] = mtol[i-1];
            end
            mv[0] = vld;
            mexp[0] = expv;
            mtol[0] = tol;
            if (mv[3]) begin
                data_known = !mtol[3];
                exp_data   = mexp[3];
            end
        end
        #1;
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mv[3]});
        if (mv[3] && mtol[3]) begin
            err = sm2int(data_out) - sm2int(mexp[3]);
            if (err < 0) err = -err;
            checkOutput($sformatf("roundtrip x=%0d err=%0d over4", sm2int(mexp[3]), err),
                        {31'd0, err > 4}, 32'd0);
        end else if (data_known) begin
            checkOutput($sformatf("data_out in=%h", din), {16'd0, data_out}, {16'd0, exp_data});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic vec(input logic [15:0] din, input logic [15:0] expv);
        applyStimulus(1'b0, 1'b1, din, expv, 1'b0);
    endtask

    initial begin
        int r;
        int ax;
        logic [15:0] y;
        logic [15:0] xs;

        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            mexp[i] = '0;
            mtol[i] = 1'b0;
        end
        exp_data   = '0;
        data_known = 1'b1;

        applyStimulus(1'b1, 1'b1, 16'h0400, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

        vec(16'd1024, 16'h0000);
        idle(5);

        // Segment edges and clamps, separated by bubbles so holds are exercised
        vec(16'd1514, 16'h0857);  idle(1);
        vec(16'd534,  16'h8857);  idle(1);
        vec(16'd1782, 16'h0F47);  idle(1);
        vec(16'd2048, 16'h46AA);  idle(1);
        vec(16'd0,    16'hC6AA);  idle(1);
        vec(16'h8123, 16'hC6AA);  idle(1);
        vec(16'h7FFF, 16'h46AA);  idle(1);
        vec(16'h8000, 16'hC6AA);  idle(1);
        vec(16'd1515, 16'h0863);
        vec(16'd1941, 16'h176F);
        vec(16'd1942, 16'h1789);
        vec(16'd2020, 16'h2389);
        vec(16'd2021, 16'h22AA);
        vec(16'd1023, 16'h8004);
        idle(6);

        // Back-to-back stream with a two-cycle bubble
        vec(16'd1024, 16'h0000);
        vec(16'd1514, 16'h0857);
        vec(16'd534,  16'h8857);
        vec(16'd2048, 16'h46AA);
        idle(2);
        vec(16'd1782, 16'h0F47);
        idle(6);

        // Reset with three samples in flight; the sample offered during reset is dropped
        vec(16'd1514, 16'h0857);
        vec(16'd534,  16'h8857);
        vec(16'd1782, 16'h0F47);
        applyStimulus(1'b1, 1'b1, 16'd2048, 16'h46AA, 1'b0);
        vec(16'd1941, 16'h176F);
        idle(6);

        // Round trip through a forward R5 line: y = 1024 +/- round(|x|*2048/8924)
        for (int x = -2100; x <= 2100; x += 5) begin
            ax = (x < 0) ? -x : x;
            r  = (ax * 2048 + 4462) / 8924;
            y  = 16'((x < 0) ? (1024 - r) : (1024 + r));
            xs = (x < 0) ? {1'b1, 15'(ax)} : {1'b0, 15'(ax)};
            applyStimulus(1'b0, 1'b1, y, xs, 1'b1);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
